// File: rtl/sw_pkg.sv
// Shared sizing constants for the slide-switch debouncer.
package sw_pkg;
  localparam int SW_WIDTH                 = 10;
  localparam int SW_STABLE_CYCLES_DEFAULT = 50000;
  localparam int SW_CNT_W                 = 16;
endpackage

// File: rtl/sw_debounce_db_bit.sv
// One switch bit: two-flop synchroniser, stability counter and edge strobes.
module db_bit
  import sw_pkg::*;
#(
  parameter int CNT_W         = SW_CNT_W,
  parameter int STABLE_CYCLES = SW_STABLE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sw,
  output logic o_db,
  output logic o_rise,
  output logic o_fall,
  output logic o_accept_next
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_db;
  logic             r_rise;
  logic             r_fall;
  logic [CNT_W-1:0] r_cnt;

  logic w_differ;
  logic w_accept;

  assign w_differ = r_s2 ^ r_db;
  assign w_accept = w_differ && (r_cnt == LP_LAST);

  // The counter only runs while the synchronised level disagrees with the accepted one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_db   <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_s1   <= i_sw;
      r_s2   <= r_s1;
      r_rise <= w_accept & r_s2;
      r_fall <= w_accept & ~r_s2;
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt <= '0;
        r_db  <= r_s2;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_db          = r_db;
  assign o_rise        = r_rise;
  assign o_fall        = r_fall;
  assign o_accept_next = w_accept;

endmodule

// File: rtl/sw_debounce.sv
// Debounces a bank of slide switches and reports per-bit edges plus an any-change flag.
module sw_debounce
  import sw_pkg::*;
#(
  parameter int WIDTH         = SW_WIDTH,
  parameter int CNT_W         = SW_CNT_W,
  parameter int STABLE_CYCLES = SW_STABLE_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             changed
);

  logic [WIDTH-1:0] w_accept_next;
  logic             r_changed;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    db_bit #(
      .CNT_W        (CNT_W),
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_bit (
      .clk          (clk),
      .rst          (rst),
      .i_sw         (sw[g]),
      .o_db         (sw_db[g]),
      .o_rise       (sw_rise[g]),
      .o_fall       (sw_fall[g]),
      .o_accept_next(w_accept_next[g])
    );
  end

  // Built from the pre-register accept terms so it lands in the same cycle as the strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_changed <= 1'b0;
    end else begin
      r_changed <= |w_accept_next;
    end
  end

  assign changed = r_changed;

endmodule

// File: tb/tb_sw_debounce.sv
// Randomised and directed bench for sw_debounce against a sliding-window reference model.
module tb_sw_debounce;

  localparam int W = 10;
  localparam int S = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] sw;
  logic [W-1:0] sw_db;
  logic [W-1:0] sw_rise;
  logic [W-1:0] sw_fall;
  logic         changed;

  int checks   = 0;
  int failures = 0;

  sw_debounce #(
    .WIDTH        (W),
    .CNT_W        (16),
    .STABLE_CYCLES(S)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sw     (sw),
    .sw_db  (sw_db),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall),
    .changed(changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: a bit flips once the last S synchronised samples since its last change all disagree with it.
  logic [W-1:0] mS1, mS2, mDb, mRise, mFall;
  logic         mChanged;
  logic [W-1:0] hist[$];
  int           sinceAccept[W];
  bit           modelValid = 0;

  always @(posedge clk) begin
    if (rst) begin
      mS1 = '0; mS2 = '0; mDb = '0; mRise = '0; mFall = '0; mChanged = 1'b0;
      hist.delete();
      for (int i = 0; i < W; i++) sinceAccept[i] = 0;
      modelValid = 1;
    end else if (modelValid) begin
      hist.push_back(mS2);
      if (hist.size() > S) void'(hist.pop_front());
      mRise = '0;
      mFall = '0;
      for (int i = 0; i < W; i++) begin
        bit allDiffer;
        sinceAccept[i]++;
        allDiffer = (hist.size() == S);
        foreach (hist[j]) if (hist[j][i] == mDb[i]) allDiffer = 0;
        if (sinceAccept[i] >= S && allDiffer) begin
          mDb[i] = ~mDb[i];
          if (mDb[i]) mRise[i] = 1'b1;
          else        mFall[i] = 1'b1;
          sinceAccept[i] = 0;
        end
      end
      mChanged = |(mRise | mFall);
      mS2 = mS1;
      mS1 = sw;
    end
  end

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("model_sw_db",   sw_db,   mDb);
      checkOutput("model_sw_rise", sw_rise, mRise);
      checkOutput("model_sw_fall", sw_fall, mFall);
      checkOutput("model_changed", {{(W-1){1'b0}}, changed}, {{(W-1){1'b0}}, mChanged});
    end
  end

  task automatic stepEdges(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] value, input logic rstVal, input int cycles);
    sw  = value;
    rst = rstVal;
    stepEdges(cycles);
  endtask

  task automatic checkAll(input string name, input logic [W-1:0] eDb, input logic [W-1:0] eRise,
                          input logic [W-1:0] eFall, input logic eChg);
    checkOutput({name, "_db"},   sw_db,   eDb);
    checkOutput({name, "_rise"}, sw_rise, eRise);
    checkOutput({name, "_fall"}, sw_fall, eFall);
    checkOutput({name, "_chg"},  {{(W-1){1'b0}}, changed}, {{(W-1){1'b0}}, eChg});
  endtask

  logic [W-1:0] expDb;
  logic [W-1:0] curSw;

  initial begin
    rst = 1'b1;
    sw  = '0;

    // Reset with all switches high, then release
    applyStimulus(10'h3FF, 1'b1, 3);
    checkAll("rst_hold", 10'h000, 10'h000, 10'h000, 1'b0);
    applyStimulus(10'h3FF, 1'b0, 5);
    checkAll("rst_k4", 10'h000, 10'h000, 10'h000, 1'b0);
    stepEdges(1);
    checkAll("rst_k5", 10'h3FF, 10'h3FF, 10'h000, 1'b1);
    stepEdges(1);
    checkAll("rst_k6", 10'h3FF, 10'h000, 10'h000, 1'b0);

    // Single rise on bit 0
    applyStimulus(10'h000, 1'b0, 12);
    checkAll("settle0", 10'h000, 10'h000, 10'h000, 1'b0);
    applyStimulus(10'h001, 1'b0, 5);
    checkAll("rise_k4", 10'h000, 10'h000, 10'h000, 1'b0);
    stepEdges(1);
    checkAll("rise_k5", 10'h001, 10'h001, 10'h000, 1'b1);
    stepEdges(1);
    checkAll("rise_k6", 10'h001, 10'h000, 10'h000, 1'b0);

    // Bounce of three cycles on bit 3 is rejected
    applyStimulus(10'h009, 1'b0, 3);
    sw = 10'h001;
    for (int i = 0; i < 10; i++) begin
      stepEdges(1);
      checkAll("bounce", 10'h001, 10'h000, 10'h000, 1'b0);
    end

    // Simultaneous fall and rise on different bits
    applyStimulus(10'h002, 1'b0, 12);
    checkAll("settle2", 10'h002, 10'h000, 10'h000, 1'b0);
    applyStimulus(10'h004, 1'b0, 5);
    checkAll("simul_k4", 10'h002, 10'h000, 10'h000, 1'b0);
    stepEdges(1);
    checkAll("simul_k5", 10'h004, 10'h004, 10'h002, 1'b1);

    // Reset in the middle of a count
    applyStimulus(10'h000, 1'b0, 12);
    applyStimulus(10'h020, 1'b0, 4);
    applyStimulus(10'h020, 1'b1, 1);
    checkAll("midrst", 10'h000, 10'h000, 10'h000, 1'b0);
    applyStimulus(10'h020, 1'b0, 5);
    checkAll("midrst_k4", 10'h000, 10'h000, 10'h000, 1'b0);
    stepEdges(1);
    checkAll("midrst_k5", 10'h020, 10'h020, 10'h000, 1'b1);
    stepEdges(2);

    // Toggle bit 9 every eight cycles
    curSw = 10'h020;
    expDb = 10'h020;
    for (int t = 0; t < 8; t++) begin
      curSw = curSw ^ 10'h200;
      applyStimulus(curSw, 1'b0, 5);
      checkOutput("toggle_hold", sw_db, expDb);
      stepEdges(1);
      expDb = curSw;
      checkOutput("toggle_db",   sw_db,   expDb);
      checkOutput("toggle_rise", sw_rise, curSw[9] ? 10'h200 : 10'h000);
      checkOutput("toggle_fall", sw_fall, curSw[9] ? 10'h000 : 10'h200);
      stepEdges(2);
    end

    // Random bouncing with occasional resets; the per-cycle compare does the checking
    for (int n = 0; n < 80; n++) begin
      curSw = curSw ^ W'($urandom_range(0, 1023) & $urandom_range(0, 1023));
      if ($urandom_range(0, 19) == 0) applyStimulus(curSw, 1'b1, 1);
      applyStimulus(curSw, 1'b0, $urandom_range(1, 9));
    end
    applyStimulus(curSw, 1'b0, 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sw_debounce.md
# sw_debounce

Synchronises and debounces the raw slide-switch bank before it reaches the input-select and display logic. Each switch bit passes through a two-flop synchroniser and a per-bit stability counter. A bit's debounced value changes only after the synchronised input has differed from it for `STABLE_CYCLES` consecutive clocks. The block also emits one-cycle rise/fall strobes per bit, so downstream stages can react to edges without their own edge detectors.

## Interface
- `WIDTH`, 10: number of switch bits.
- `CNT_W`, 16: stability counter width; requires `STABLE_CYCLES - 1 < 2**CNT_W`.
- `STABLE_CYCLES`, 50000: consecutive cycles of disagreement required to accept a new level (1 ms at 50 MHz); must be ≥ 2.

Ports:
- `clk` in, 1: single clock; all state updates on its rising edge.
- `rst` in, 1: reset, synchronous, active-high.
- `sw` in, `WIDTH`: raw asynchronous switch levels.
- `sw_db` out, `WIDTH`: debounced, registered switch levels; feeds the select stage.
- `sw_rise` out, `WIDTH`: per-bit one-cycle strobe when `sw_db[i]` goes 0→1.
- `sw_fall` out, `WIDTH`: per-bit one-cycle strobe when `sw_db[i]` goes 1→0.
- `changed` out, 1: OR of all bits of `sw_rise | sw_fall`, registered alongside them.

## Operation
Per-bit state:
- `s1[i]`, `s2[i]`: two synchroniser flops.
- `cnt[i]`: `CNT_W`-bit counter.
- `sw_db[i]`: accepted level.

Per-bit update on each clock edge when `rst` = 0:
- `s1 <= sw[i]`, then `s2 <= s1`.
- If `s2 == sw_db[i]`: `cnt <= 0`, no strobe.
- If `s2 != sw_db[i]` and `cnt != STABLE_CYCLES-1`: `cnt <= cnt + 1`.
- If `s2 != sw_db[i]` and `cnt == STABLE_CYCLES-1`:
  - `sw_db[i] <= s2` and `cnt <= 0`.
  - Set `sw_rise[i] <= s2` and `sw_fall[i] <= ~s2` for that one cycle.
- The strobes are 0 in every other cycle.

Behaviour rules:
- **Bounces:** any return of `s2` to `sw_db[i]` before the count completes clears `cnt`, so a bounce shorter than `STABLE_CYCLES` cycles produces no output change and no strobe.
- **Counter range:** `cnt` never exceeds `STABLE_CYCLES-1` and never wraps.
- **Independence:** bits are fully independent, and any number of bits may update in the same cycle. `changed` is 1 in that cycle if any strobe is set.
- **Reset:** `rst` = 1 clears `s1`, `s2`, `cnt`, `sw_db`, `sw_rise`, `sw_fall` and `changed` to 0 at the next edge. This holds regardless of in-progress counts, and no strobe is generated by reset.
- **After reset:** switches already high are accepted through the normal path and produce `sw_rise` strobes.

## Timing
- Reset values: `sw_db` = 0, `sw_rise` = 0, `sw_fall` = 0, `changed` = 0.
- Latency: let a new level on `sw[i]` be first captured by `s1` at edge k, and hold it stable.
  - `s2` updates at edge k+1.
  - `cnt` reaches j at edge k+1+j.
  - `sw_db[i]`, the strobe and `changed` update at edge k+1+`STABLE_CYCLES`, i.e. `STABLE_CYCLES`+1 edges after capture.
- Strobes are high for exactly one cycle, coincident with the first cycle of the new `sw_db` value.
- Minimum spacing between accepted changes on one bit is `STABLE_CYCLES` cycles.
- All outputs are registered, with no combinational path from `sw` to any output.

## Structure
- Shared package `sw_pkg`:
  - `SW_WIDTH` = 10.
  - `SW_STABLE_CYCLES_DEFAULT` = 50000.
  - `SW_CNT_W` = 16.
- Sub-module `db_bit`:
  - Single-bit synchroniser, counter and strobe logic.
  - Parameters `CNT_W` and `STABLE_CYCLES`.
  - Instantiated `WIDTH` times by a generate loop.
- `sw_debounce` itself only concatenates the per-bit strobes and registers the OR into `changed`.

## Test plan
Run all scenarios with `STABLE_CYCLES` = 4 and `WIDTH` = 10.
1. **Reset with switches high:** hold `rst` with `sw` = 10'h3FF → all outputs 0 during reset. After release, with k the first edge with `rst` = 0: `sw_db` = 10'h3FF from edge k+5, `sw_rise` = 10'h3FF for one cycle, `changed` = 1 for one cycle.
2. **Single rise:** from `sw` = 0 settled, set `sw[0]` = 1 and hold → `sw_db[0]` rises exactly 5 edges after capture. `sw_rise` = 10'h001 and `changed` = 1 for that cycle only; `sw_fall` stays 0.
3. **Bounce rejection:** pulse `sw[3]` high for 3 cycles, then low for 10 cycles → `sw_db` unchanged, no strobes, `changed` stays 0.
4. **Simultaneous edges:** from `sw_db` = 10'h002, drive `sw` = 10'h004 in one cycle → at the same edge `sw_db` = 10'h004, `sw_fall` = 10'h002, `sw_rise` = 10'h004, `changed` = 1.
5. **Reset mid-count:** raise `sw[5]`, then assert `rst` for one edge when `cnt` = 2 → outputs stay 0. After release the bit takes the full 5 edges from recapture before `sw_db[5]` = 1.
6. **Repeated toggling:** toggle `sw[9]` every 8 cycles for 4 periods → `sw_db[9]` follows each level with a constant 5-edge latency, with alternating single-cycle `sw_rise[9]` and `sw_fall[9]` strobes.
